// File: rtl/axi_lite_mem_bank.sv
// Word-addressed on-chip memory behind the AXI4-Lite slave.
// Self-initialises after reset, range-checks every access and keeps error statistics.
module axi_lite_mem_bank #(
    parameter int          DEPTH      = 256,
    parameter int          AW         = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_wr_en,
    input  logic [31:0] mem_wr_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_rd_en,
    input  logic [31:0] mem_rd_addr,
    output logic [31:0] mem_rd_data,
    input  logic        clr_err,
    output logic        init_done,
    output logic        err_oor,
    output logic        err_busy,
    output logic [15:0] err_cnt
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [29:0]   DEPTH_W  = 30'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state, state_next;
    logic [AW-1:0] ptr, ptr_next;
    logic          init_wr;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   wr_off, rd_off;
    logic [AW-1:0] wr_idx, rd_idx;
    logic          wr_valid, rd_valid;
    logic          wr_ok, wr_oor, wr_busy, rd_oor;
    logic [31:0]   rd_value;
    logic [1:0]    err_inc;
    logic [15:0]   cnt_base;
    logic [16:0]   cnt_sum;
    logic [15:0]   err_cnt_next;

    // Address decode; the subtraction wraps for addresses below BASE_ADDR, hence the explicit compare.
    assign wr_off   = mem_wr_addr - BASE_ADDR;
    assign rd_off   = mem_rd_addr - BASE_ADDR;
    assign wr_idx   = wr_off[AW+1:2];
    assign rd_idx   = rd_off[AW+1:2];
    assign wr_valid = (mem_wr_addr >= BASE_ADDR) && (wr_off[1:0] == 2'b00) && (wr_off[31:2] < DEPTH_W);
    assign rd_valid = (mem_rd_addr >= BASE_ADDR) && (rd_off[1:0] == 2'b00) && (rd_off[31:2] < DEPTH_W);

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        init_wr    = 1'b0;
        case (state)
            S_INIT: begin
                init_wr  = 1'b1;
                ptr_next = ptr + 1'b1;
                if (ptr == LAST_IDX) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                state_next = S_RUN;
            end
        endcase
    end

    // During INIT only words at or below the sweep pointer may take user writes.
    always_comb begin
        wr_ok   = mem_wr_en && wr_valid && ((state == S_RUN) || (wr_idx <= ptr));
        wr_oor  = mem_wr_en && !wr_valid;
        wr_busy = mem_wr_en && wr_valid && (state == S_INIT) && (wr_idx > ptr);
        rd_oor  = mem_rd_en && !rd_valid;

        rd_value = mem[rd_idx];
        if (!rd_valid) begin
            rd_value = ERR_DATA;
        end else if (wr_ok && (wr_idx == rd_idx)) begin
            rd_value = mem_wr_data;
        end else if ((state == S_INIT) && (rd_idx >= ptr)) begin
            rd_value = INIT_VALUE;
        end

        err_inc      = {1'b0, wr_oor} + {1'b0, rd_oor} + {1'b0, wr_busy};
        cnt_base     = clr_err ? 16'h0000 : err_cnt;
        cnt_sum      = {1'b0, cnt_base} + 17'(err_inc);
        err_cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    // The user write is placed after the init write so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (init_wr) begin
            mem[ptr] <= INIT_VALUE;
        end
        if (wr_ok) begin
            mem[wr_idx] <= mem_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT;
            ptr         <= '0;
            mem_rd_data <= 32'h0000_0000;
            init_done   <= 1'b0;
            err_oor     <= 1'b0;
            err_busy    <= 1'b0;
            err_cnt     <= 16'h0000;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            init_done <= (state == S_RUN);
            if (mem_rd_en) begin
                mem_rd_data <= rd_value;
            end
            err_oor  <= (err_oor && !clr_err) || wr_oor || rd_oor;
            err_busy <= (err_busy && !clr_err) || wr_busy;
            err_cnt  <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_bank.sv
// Scoreboard bench for axi_lite_mem_bank: directed vectors push expected read data,
// a negedge monitor pops and compares whenever a read result is due.
module tb_axi_lite_mem_bank;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_wr_en;
    logic [31:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd_en;
    logic [31:0] mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        clr_err;
    logic        init_done;
    logic        err_oor;
    logic        err_busy;
    logic [15:0] err_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic        rd_seen;

    axi_lite_mem_bank #(
        .DEPTH(DEPTH),
        .AW(8),
        .BASE_ADDR(32'h0000_0000),
        .INIT_VALUE(32'h0000_0000),
        .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_wr_en(mem_wr_en),
        .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .clr_err(clr_err),
        .init_done(init_done),
        .err_oor(err_oor),
        .err_busy(err_busy),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus; inputs return to idle right after the sampling edge.
    task automatic applyStimulus(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                                 input logic re, input logic [31:0] ra, input logic clr,
                                 input logic [31:0] exp_rd);
        mem_wr_en   = we;
        mem_wr_addr = wa;
        mem_wr_data = wd;
        mem_rd_en   = re;
        mem_rd_addr = ra;
        clr_err     = clr;
        if (re) exp_q.push_back(exp_rd);
        @(posedge clk);
        #1;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        clr_err   = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic checkStatus(input string tag, input logic oor, input logic busy, input logic [15:0] cnt);
        checkOutput({tag, "_err_oor"}, {31'b0, err_oor}, {31'b0, oor});
        checkOutput({tag, "_err_busy"}, {31'b0, err_busy}, {31'b0, busy});
        checkOutput({tag, "_err_cnt"}, {16'b0, err_cnt}, {16'b0, cnt});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_seen <= 1'b0;
        else        rd_seen <= mem_rd_en;
    end

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got %h expected no read result", mem_rd_data);
            end else begin
                checkOutput("rd_data", mem_rd_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = 32'h0;
        mem_wr_data = 32'h0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = 32'h0;
        clr_err     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rd_data", mem_rd_data, 32'h0);
        checkOutput("reset_init_done", {31'b0, init_done}, 32'h0);
        checkStatus("reset", 1'b0, 1'b0, 16'h0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= DEPTH + 1; e++) begin
            idle();
            checkOutput("init_done_p1", {31'b0, init_done}, {31'b0, (e >= DEPTH + 1)});
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_0000, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0000_03FC, 1'b0, 32'h0);
        checkStatus("after_init", 1'b0, 1'b0, 16'h0);

        // Normal RUN traffic, write-first and the top word.
        applyStimulus(1'b1, 32'h10, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 32'hA5A5_0001);
        applyStimulus(1'b1, 32'h20, 32'h1234_5678, 1'b1, 32'h20, 1'b0, 32'h1234_5678);
        applyStimulus(1'b1, 32'h3FC, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h3FC, 1'b0, 32'hCAFE_F00D);
        checkStatus("run_ok", 1'b0, 1'b0, 16'h0);

        applyStimulus(1'b1, 32'h400, 32'h5555_AAAA, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h402, 1'b0, 32'hDEAD_BEEF);
        checkStatus("oor", 1'b1, 1'b0, 16'd2);
        idle();
        checkOutput("rd_hold", mem_rd_data, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h11, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 32'hA5A5_0001);
        checkStatus("misalign", 1'b1, 1'b0, 16'd3);

        // Saturation of the error counter and clear-with-error.
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        checkStatus("clr", 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 32767; i++) begin
            applyStimulus(1'b1, 32'h400, 32'h0, 1'b1, 32'h401, 1'b0, 32'hDEAD_BEEF);
        end
        checkStatus("sat_fffe", 1'b1, 1'b0, 16'hFFFE);
        applyStimulus(1'b1, 32'h800, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checkStatus("sat_ffff", 1'b1, 1'b0, 16'hFFFF);
        applyStimulus(1'b1, 32'h800, 32'h0, 1'b1, 32'h803, 1'b0, 32'hDEAD_BEEF);
        checkStatus("sat_hold", 1'b1, 1'b0, 16'hFFFF);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b1, 32'hDEAD_BEEF);
        checkStatus("clr_same_cycle", 1'b1, 1'b0, 16'd1);
        idle();

        // Asynchronous reset mid-run, then traffic while the sweep is in progress.
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_rd_data", mem_rd_data, 32'h0);
        checkOutput("rst2_init_done", {31'b0, init_done}, 32'h0);
        checkStatus("rst2", 1'b0, 1'b0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= DEPTH + 1; e++) begin
            case (e)
                6:  applyStimulus(1'b1, 32'h14, 32'h22, 1'b0, 32'h0, 1'b0, 32'h0);
                7:  applyStimulus(1'b1, 32'h0C, 32'h11, 1'b0, 32'h0, 1'b0, 32'h0);
                8:  applyStimulus(1'b1, 32'h24, 32'h33, 1'b0, 32'h0, 1'b0, 32'h0);
                9:  applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0);
                10: applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h14, 1'b0, 32'h22);
                11: applyStimulus(1'b1, 32'h28, 32'h44, 1'b1, 32'h28, 1'b0, 32'h44);
                12: applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h3FC, 1'b0, 32'h0);
                default: idle();
            endcase
            if (e == 7) checkStatus("init_ok", 1'b0, 1'b0, 16'h0);
            if (e == 8) checkStatus("init_busy", 1'b0, 1'b1, 16'd1);
            checkOutput("init_done_p2", {31'b0, init_done}, {31'b0, (e >= DEPTH + 1)});
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0C, 1'b0, 32'h11);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h14, 1'b0, 32'h22);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h24, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h28, 1'b0, 32'h44);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 32'h0);
        idle();
        idle();
        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
